alu_op_issue: RTL and testbench

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

---
 rtl/alu_op_pkg.sv | 42 ++++
 rtl/alu_op_lut.sv | 59 +++++
 rtl/alu_op_issue.sv | 134 +++++++++++++
 tb/tb_alu_op_issue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_pkg.sv
// Shared RV32I opcode constants, ALU operation codes and skid-buffer state encoding
// for the ALU operation issue stage.
package alu_op_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLTI = 4'b0011,
        ALU_SRA  = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_EQ   = 4'b1000,
        ALU_SLL  = 4'b1001,
        ALU_ADDI = 4'b1100,
        ALU_SRL  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    // One decoded entry as held in the skid buffer.
    typedef struct packed {
        alu_op_e op;
        logic    alu_src;
        logic    illegal;
    } dec_t;

endpackage

// File: rtl/alu_op_lut.sv
// Combinational RV32I field-to-ALU-operation table; unsupported encodings decode
// to operation 0000, ALUSrc 0, illegal 1.
module alu_op_lut
    import alu_op_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec
);

    always_comb begin
        dec = '{op: ALU_AND, alu_src: 1'b0, illegal: 1'b1};
        case (opcode)
            OPC_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO)
                            dec = '{op: ALU_ADD, alu_src: 1'b0, illegal: 1'b0};
                        else if (funct7 == F7_ALT)
                            dec = '{op: ALU_SUB, alu_src: 1'b0, illegal: 1'b0};
                    end
                    3'b111:  dec = '{op: ALU_AND, alu_src: 1'b0, illegal: 1'b0};
                    3'b110:  dec = '{op: ALU_OR,  alu_src: 1'b0, illegal: 1'b0};
                    3'b100:  dec = '{op: ALU_XOR, alu_src: 1'b0, illegal: 1'b0};
                    3'b010:  dec = '{op: ALU_SLT, alu_src: 1'b0, illegal: 1'b0};
                    default: ;
                endcase
            end
            OPC_ITYPE: begin
                case (funct3)
                    3'b000:  dec = '{op: ALU_ADDI, alu_src: 1'b1, illegal: 1'b0};
                    3'b010:  dec = '{op: ALU_SLTI, alu_src: 1'b1, illegal: 1'b0};
                    3'b111:  dec = '{op: ALU_AND,  alu_src: 1'b1, illegal: 1'b0};
                    3'b110:  dec = '{op: ALU_OR,   alu_src: 1'b1, illegal: 1'b0};
                    3'b100:  dec = '{op: ALU_XOR,  alu_src: 1'b1, illegal: 1'b0};
                    3'b001: begin
                        if (funct7 == F7_ZERO)
                            dec = '{op: ALU_SLL, alu_src: 1'b1, illegal: 1'b0};
                    end
                    3'b101: begin
                        if (funct7 == F7_ZERO)
                            dec = '{op: ALU_SRL, alu_src: 1'b1, illegal: 1'b0};
                        else if (funct7 == F7_ALT)
                            dec = '{op: ALU_SRA, alu_src: 1'b1, illegal: 1'b0};
                    end
                    default: ;
                endcase
            end
            OPC_LOAD, OPC_STORE: dec = '{op: ALU_ADD, alu_src: 1'b1, illegal: 1'b0};
            OPC_BRANCH: begin
                if (funct3 == 3'b000)
                    dec = '{op: ALU_EQ, alu_src: 1'b0, illegal: 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// ALU operation issue stage: registered decode behind a 2-entry skid buffer with
// valid/ready handshake. Optional illegal-entry counter under ALU_OP_ISSUE_ILLEGAL_CNT_EN.
//
// state      | meaning
// SKID_EMPTY | nothing held, out_valid 0, in_ready 1
// SKID_ONE   | head entry presented, in_ready 1
// SKID_FULL  | head presented, second entry parked in skid slot, in_ready 0
module alu_op_issue
    import alu_op_pkg::*;
#(
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ALUSrc,
    output logic                     illegal
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]              illegal_cnt
`endif
);

    localparam dec_t DEC_RESET = '{op: ALU_AND, alu_src: 1'b0, illegal: 1'b0};

    skid_state_e r_state;
    skid_state_e w_state_nxt;
    dec_t        r_head;
    dec_t        r_skid;
    dec_t        w_dec;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_head_from_in;
    logic        w_head_from_skid;
    logic        w_skid_load;

    alu_op_lut u_lut (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .dec    (w_dec)
    );

    assign in_ready   = (r_state != SKID_FULL);
    assign out_valid  = (r_state != SKID_EMPTY);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    assign Operation = OPCODE_LENGTH'(r_head.op);
    assign ALUSrc    = r_head.alu_src;
    assign illegal   = r_head.illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= SKID_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt    = SKID_ONE;
                    w_head_from_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_head_from_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = SKID_FULL;
                    w_skid_load = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (w_out_xfer) begin
                    w_state_nxt      = SKID_ONE;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
        // Flush wins over any simultaneous accept or issue.
        if (flush) begin
            w_state_nxt      = SKID_EMPTY;
            w_head_from_in   = 1'b0;
            w_head_from_skid = 1'b0;
            w_skid_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= DEC_RESET;
            r_skid <= DEC_RESET;
        end else begin
            if (w_head_from_in)
                r_head <= w_dec;
            else if (w_head_from_skid)
                r_head <= r_skid;
            if (w_skid_load)
                r_skid <= w_dec;
        end
    end

`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
    logic [15:0] r_illegal_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_illegal_cnt <= 16'h0000;
        else if (w_out_xfer && !flush && r_head.illegal && (r_illegal_cnt != 16'hFFFF))
            r_illegal_cnt <= r_illegal_cnt + 16'h0001;
    end

    assign illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: decode vector table plus handshake,
// flush and reset sequences; counter checks when ALU_OP_ISSUE_ILLEGAL_CNT_EN is defined.
module tb_alu_op_issue;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Operation;
    logic       ALUSrc;
    logic       illegal;
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_issue #(.OPCODE_LENGTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Operation (Operation),
        .ALUSrc    (ALUSrc),
        .illegal   (illegal)
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] op;
        logic       src;
        logic       ill;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        in_valid = v;
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
    endtask

    initial begin
        vecs[0]  = '{7'b0110011, 3'b000, 7'b0000000, 4'b0010, 1'b0, 1'b0};
        vecs[1]  = '{7'b0110011, 3'b000, 7'b0100000, 4'b0110, 1'b0, 1'b0};
        vecs[2]  = '{7'b0110011, 3'b111, 7'b0000000, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{7'b0110011, 3'b110, 7'b0000000, 4'b0001, 1'b0, 1'b0};
        vecs[4]  = '{7'b0110011, 3'b100, 7'b0000000, 4'b0101, 1'b0, 1'b0};
        vecs[5]  = '{7'b0110011, 3'b010, 7'b0000000, 4'b0111, 1'b0, 1'b0};
        vecs[6]  = '{7'b0110011, 3'b000, 7'b0000001, 4'b0000, 1'b0, 1'b1};
        vecs[7]  = '{7'b0010011, 3'b000, 7'b0000000, 4'b1100, 1'b1, 1'b0};
        vecs[8]  = '{7'b0010011, 3'b010, 7'b0000000, 4'b0011, 1'b1, 1'b0};
        vecs[9]  = '{7'b0010011, 3'b111, 7'b0000000, 4'b0000, 1'b1, 1'b0};
        vecs[10] = '{7'b0010011, 3'b110, 7'b0000000, 4'b0001, 1'b1, 1'b0};
        vecs[11] = '{7'b0010011, 3'b100, 7'b0000000, 4'b0101, 1'b1, 1'b0};
        vecs[12] = '{7'b0010011, 3'b001, 7'b0000000, 4'b1001, 1'b1, 1'b0};
        vecs[13] = '{7'b0010011, 3'b101, 7'b0000000, 4'b1101, 1'b1, 1'b0};
        vecs[14] = '{7'b0010011, 3'b101, 7'b0100000, 4'b0100, 1'b1, 1'b0};
        vecs[15] = '{7'b0010011, 3'b001, 7'b0100000, 4'b0000, 1'b0, 1'b1};
        vecs[16] = '{7'b0000011, 3'b010, 7'b0000000, 4'b0010, 1'b1, 1'b0};
        vecs[17] = '{7'b0100011, 3'b010, 7'b0000000, 4'b0010, 1'b1, 1'b0};
        vecs[18] = '{7'b1100011, 3'b000, 7'b0000000, 4'b1000, 1'b0, 1'b0};
        vecs[19] = '{7'b1100011, 3'b001, 7'b0000000, 4'b0000, 1'b0, 1'b1};
        vecs[20] = '{7'b1111111, 3'b000, 7'b0000000, 4'b0000, 1'b0, 1'b1};
        vecs[21] = '{7'b0110111, 3'b000, 7'b0000000, 4'b0000, 1'b0, 1'b1};

        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_operation", {28'd0, Operation}, 32'd0);
        chk("rst_alusrc",    {31'd0, ALUSrc},    32'd0);
        chk("rst_illegal",   {31'd0, illegal},   32'd0);
        step();
        chk("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        reset_n = 1'b1;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        step();

        // Back-to-back issue with out_ready held high: one entry per cycle.
        for (int i = 0; i < 22; i++) begin
            drive(1'b1, vecs[i].opc, vecs[i].f3, vecs[i].f7);
            step();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  32'd1);
            chk($sformatf("vec%0d_operation", i), {28'd0, Operation}, {28'd0, vecs[i].op});
            chk($sformatf("vec%0d_alusrc", i),    {31'd0, ALUSrc},    {31'd0, vecs[i].src});
            chk($sformatf("vec%0d_illegal", i),   {31'd0, illegal},   {31'd0, vecs[i].ill});
        end
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        step();
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: two accepts fill the buffer, third waits.
        out_ready = 1'b0;
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
        step();
        chk("bp1_in_ready",  {31'd0, in_ready},  32'd1);
        chk("bp1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp1_operation", {28'd0, Operation}, 32'h2);
        drive(1'b1, 7'b0110011, 3'b000, 7'b0100000);
        step();
        chk("bp2_in_ready",  {31'd0, in_ready},  32'd0);
        chk("bp2_operation", {28'd0, Operation}, 32'h2);
        drive(1'b1, 7'b0110011, 3'b100, 7'b0000000);
        step();
        chk("bp3_in_ready",  {31'd0, in_ready},  32'd0);
        chk("bp3_operation", {28'd0, Operation}, 32'h2);
        out_ready = 1'b1;
        step();
        chk("bp4_operation", {28'd0, Operation}, 32'h6);
        chk("bp4_in_ready",  {31'd0, in_ready},  32'd1);
        chk("bp4_out_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("bp5_operation", {28'd0, Operation}, 32'h5);
        chk("bp5_out_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        step();
        chk("bp6_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush from FULL with a concurrent in_valid.
        out_ready = 1'b0;
        drive(1'b1, 7'b0010011, 3'b000, 7'b0000000);
        step();
        drive(1'b1, 7'b0010011, 3'b010, 7'b0000000);
        step();
        chk("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 7'b1100011, 3'b000, 7'b0000000);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("fl_full_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_full_in_ready2", {31'd0, in_ready},  32'd1);
        flush = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        step();
        chk("fl_full_no_issue", {31'd0, out_valid}, 32'd0);

        // Flush from ONE while a new entry is offered: entry dropped.
        out_ready = 1'b0;
        drive(1'b1, 7'b0010011, 3'b000, 7'b0000000);
        step();
        drive(1'b1, 7'b1100011, 3'b000, 7'b0000000);
        flush = 1'b1;
        step();
        chk("fl_one_out_valid", {31'd0, out_valid}, 32'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        step();
        chk("fl_one_no_issue", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset between edges while ONE.
        out_ready = 1'b0;
        drive(1'b1, 7'b0010011, 3'b101, 7'b0100000);
        step();
        chk("ar_pre_out_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_pre_operation", {28'd0, Operation}, 32'h4);
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_in_ready",  {31'd0, in_ready},  32'd1);
        chk("ar_operation", {28'd0, Operation}, 32'd0);
        chk("ar_alusrc",    {31'd0, ALUSrc},    32'd0);
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ar_stale%0d", k), {31'd0, out_valid}, 32'd0);
        end

        // Illegal encoding issued right after reset.
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
        chk("cnt_start", {16'd0, illegal_cnt}, 32'd0);
`endif
        drive(1'b1, 7'b1111111, 3'b000, 7'b0000000);
        step();
        chk("ill_out_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_illegal",   {31'd0, illegal},   32'd1);
        chk("ill_operation", {28'd0, Operation}, 32'd0);
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
        chk("cnt_pre_issue", {16'd0, illegal_cnt}, 32'd0);
`endif
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        step();
        chk("ill_drained", {31'd0, out_valid}, 32'd0);
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
        chk("cnt_after", {16'd0, illegal_cnt}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
